// File: rtl/zigbee_tx_pkg.sv
// rtl/zigbee_tx_pkg.sv - shared constants and types for the 802.15.4 O-QPSK transmitter
package zigbee_tx_pkg;

   localparam int SAMPLES_PER_CHIP = 5;

   // MSB of each word is chip c0
   localparam logic [31:0] CHIP_SEQ [16] = '{
      32'hD9C3522E, 32'hED9C3522, 32'h2ED9C352, 32'h22ED9C35,
      32'h522ED9C3, 32'h3522ED9C, 32'hC3522ED9, 32'h9C3522ED,
      32'h8C96077B, 32'hB8C96077, 32'h7B8C9607, 32'h77B8C960,
      32'h077B8C96, 32'h6077B8C9, 32'h96077B8C, 32'hC96077B8
   };

   localparam logic signed [3:0] HALF_SINE [10] = '{
      4'sd1, 4'sd3, 4'sd5, 4'sd6, 4'sd7, 4'sd7, 4'sd6, 4'sd5, 4'sd3, 4'sd1
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_SFD,
      ST_PAYLOAD,
      ST_TAIL
   } tx_state_t;

   function automatic logic signed [3:0] shape(input logic chip, input logic [3:0] idx);
      return chip ? HALF_SINE[idx] : -HALF_SINE[idx];
   endfunction

endpackage

// File: rtl/oqpsk_pulse_shaper.sv
// rtl/oqpsk_pulse_shaper.sv - half-sine O-QPSK shaper: chip/sample counters and registered I/Q
module oqpsk_pulse_shaper
   import zigbee_tx_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_stb,
   input  logic              i_run,
   input  logic              i_tail,
   input  logic [31:0]       i_chips,
   output logic              o_sym_end,
   output logic              o_tail_end,
   output logic signed [3:0] o_i,
   output logic signed [3:0] o_q
);

   logic [2:0]        samp;
   logic [4:0]        chip;
   logic              prev_q;
   logic              prev_valid;
   logic              active;
   logic              samp_wrap;
   logic              cur_chip;
   logic              i_chip;
   logic [3:0]        i_idx;
   logic signed [3:0] i_next;
   logic signed [3:0] q_next;

   assign active     = i_run || i_tail;
   assign samp_wrap  = (samp == 3'(SAMPLES_PER_CHIP - 1));
   assign o_sym_end  = i_stb && i_run && samp_wrap && (chip == 5'd31);
   assign o_tail_end = i_stb && i_tail && samp_wrap;

   always_comb begin
      cur_chip = i_chips[5'd31 - chip];
      i_chip   = i_chips[5'd31 - {chip[4:1], 1'b0}];
      i_idx    = chip[0] ? ({1'b0, samp} + 4'd5) : {1'b0, samp};
      i_next   = i_run ? shape(i_chip, i_idx) : 4'sd0;
      // Q lags by half a pulse: even chips finish the previous odd chip's pulse
      if (!active)
         q_next = 4'sd0;
      else if (chip[0] && i_run)
         q_next = shape(cur_chip, {1'b0, samp});
      else if (prev_valid)
         q_next = shape(prev_q, {1'b0, samp} + 4'd5);
      else
         q_next = 4'sd0;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         samp       <= '0;
         chip       <= '0;
         prev_q     <= 1'b0;
         prev_valid <= 1'b0;
         o_i        <= '0;
         o_q        <= '0;
      end else begin
         if (i_stb) begin
            o_i <= i_next;
            o_q <= q_next;
         end
         if (!active) begin
            samp       <= '0;
            chip       <= '0;
            prev_valid <= 1'b0;
         end else if (i_stb) begin
            if (samp_wrap) begin
               samp <= '0;
               chip <= chip + 5'd1;
            end else begin
               samp <= samp + 3'd1;
            end
            if (i_run && chip[0] && samp_wrap) begin
               prev_q     <= cur_chip;
               prev_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/zigbee_oqpsk_tx.sv
// rtl/zigbee_oqpsk_tx.sv - 802.15.4 O-QPSK transmitter: framing, byte holding register, DSSS spreading
module zigbee_oqpsk_tx
   import zigbee_tx_pkg::*;
#(
   parameter int         PREAMBLE_BYTES = 4,
   parameter logic [7:0] SFD_BYTE       = 8'hA7
)
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_dac_stb,
   input  logic [7:0]        i_data,
   input  logic              i_valid,
   input  logic              i_last,
   output logic              o_ready,
   output logic signed [3:0] o_I_bb,
   output logic signed [3:0] o_Q_bb,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_underrun
);

   tx_state_t  state, state_nx;
   logic [7:0] hold_data;
   logic       hold_valid;
   logic       hold_last;
   logic       last_seen;
   logic [7:0] cur_byte;
   logic       cur_last;
   logic       nib_hi;
   logic [7:0] pre_cnt;
   logic       pre_done;
   logic       run;
   logic       tail;
   logic       sym_end;
   logic       byte_end;
   logic       tail_end;
   logic       take;
   logic       done_nx;
   logic       underrun_nx;
   logic [3:0] nibble;

   assign run      = (state == ST_PRE) || (state == ST_SFD) || (state == ST_PAYLOAD);
   assign tail     = (state == ST_TAIL);
   assign o_busy   = (state != ST_IDLE);
   assign o_ready  = o_busy && !hold_valid && !last_seen;
   assign nibble   = nib_hi ? cur_byte[7:4] : cur_byte[3:0];
   assign byte_end = sym_end && nib_hi;
   assign pre_done = (pre_cnt == 8'(PREAMBLE_BYTES - 1));

   oqpsk_pulse_shaper u_shaper (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_stb      (i_dac_stb),
      .i_run      (run),
      .i_tail     (tail),
      .i_chips    (CHIP_SEQ[nibble]),
      .o_sym_end  (sym_end),
      .o_tail_end (tail_end),
      .o_i        (o_I_bb),
      .o_q        (o_Q_bb)
   );

   always_comb begin
      state_nx    = state;
      take        = 1'b0;
      done_nx     = 1'b0;
      underrun_nx = 1'b0;
      case (state)
         ST_IDLE:    if (i_valid) state_nx = ST_PRE;
         ST_PRE:     if (byte_end && pre_done) state_nx = ST_SFD;
         ST_SFD, ST_PAYLOAD: begin
            if (byte_end) begin
               if (state == ST_PAYLOAD && cur_last) begin
                  state_nx = ST_TAIL;
               end else if (hold_valid) begin
                  take     = 1'b1;
                  state_nx = ST_PAYLOAD;
               end else begin
                  underrun_nx = 1'b1;
                  state_nx    = ST_TAIL;
               end
            end
         end
         ST_TAIL: begin
            if (tail_end) begin
               done_nx  = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default:    state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= ST_IDLE;
         hold_data  <= '0;
         hold_valid <= 1'b0;
         hold_last  <= 1'b0;
         last_seen  <= 1'b0;
         cur_byte   <= '0;
         cur_last   <= 1'b0;
         nib_hi     <= 1'b0;
         pre_cnt    <= '0;
         o_done     <= 1'b0;
         o_underrun <= 1'b0;
      end else begin
         state      <= state_nx;
         o_done     <= done_nx;
         o_underrun <= underrun_nx;
         if (state == ST_IDLE) begin
            hold_valid <= 1'b0;
            last_seen  <= 1'b0;
            cur_byte   <= '0;
            cur_last   <= 1'b0;
            nib_hi     <= 1'b0;
            pre_cnt    <= '0;
         end else begin
            if (sym_end)
               nib_hi <= !nib_hi;
            // preamble bytes are zero, so cur_byte only changes when the SFD is due
            if (byte_end && state == ST_PRE) begin
               if (pre_done)
                  cur_byte <= SFD_BYTE;
               else
                  pre_cnt <= pre_cnt + 8'd1;
            end
            if (take) begin
               cur_byte   <= hold_data;
               cur_last   <= hold_last;
               hold_valid <= 1'b0;
            end
            if (i_valid && o_ready) begin
               hold_data  <= i_data;
               hold_last  <= i_last;
               hold_valid <= 1'b1;
               last_seen  <= i_last;
            end
         end
      end
   end

endmodule

// File: tb/tb_zigbee_oqpsk_tx.sv
// tb/tb_zigbee_oqpsk_tx.sv - directed self-checking bench for zigbee_oqpsk_tx
module tb_zigbee_oqpsk_tx;

   logic              clk = 1'b0;
   logic              rst_n, stb, valid, last;
   logic [7:0]        data;
   logic              ready, busy, done, underrun;
   logic signed [3:0] s_i, s_q;

   int checks   = 0;
   int failures = 0;

   logic signed [3:0] cap_i [2100];
   logic signed [3:0] cap_q [2100];
   logic signed [3:0] ref_i [2100];
   logic signed [3:0] ref_q [2100];
   logic [7:0]        byte_q [2];
   int ns, done_cnt, done_at, und_cnt, und_at, stable_err, bidx, cur_n, cur_avail, errs;
   int hs [10] = '{1, 3, 5, 6, 7, 7, 6, 5, 3, 1};

   zigbee_oqpsk_tx dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_dac_stb  (stb),
      .i_data     (data),
      .i_valid    (valid),
      .i_last     (last),
      .o_ready    (ready),
      .o_I_bb     (s_i),
      .o_Q_bb     (s_q),
      .o_busy     (busy),
      .o_done     (done),
      .o_underrun (underrun)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic s);
      logic acc;
      stb = s;
      acc = valid && ready;
      @(posedge clk);
      #1;
      stb = 1'b0;
      if (acc) begin
         bidx++;
         if (bidx < cur_avail) begin
            data = byte_q[bidx];
            last = (bidx == cur_n - 1);
         end else begin
            valid = 1'b0;
         end
      end
      if (s) begin
         if (ns < 2100) begin
            cap_i[ns] = s_i;
            cap_q[ns] = s_q;
         end
         ns++;
      end
      if (done) begin
         done_cnt++;
         done_at = ns;
      end
      if (underrun) begin
         und_cnt++;
         und_at = ns;
      end
   endtask

   task automatic run_frame(input int nbytes, input int avail, input bit rnd, input int stop_after);
      int gap;
      int limit;
      limit      = (stop_after < 2100) ? stop_after : 2100;
      ns         = 0;
      done_cnt   = 0;
      done_at    = -1;
      und_cnt    = 0;
      und_at     = -1;
      stable_err = 0;
      bidx       = 0;
      cur_n      = nbytes;
      cur_avail  = avail;
      valid      = 1'b1;
      data       = byte_q[0];
      last       = (nbytes == 1);
      cycle(1'b0);
      while (done_cnt == 0 && ns < limit) begin
         gap = 5;
         if (rnd && $urandom_range(0, 3) == 0)
            gap = $urandom_range(5, 40);
         repeat (gap - 1) begin
            cycle(1'b0);
            if (ns > 0 && ns <= 2100 && (s_i !== cap_i[ns-1] || s_q !== cap_q[ns-1]))
               stable_err++;
         end
         cycle(1'b1);
      end
      valid = 1'b0;
      last  = 1'b0;
      repeat (3) cycle(1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      stb   = 1'b0;
      valid = 1'b0;
      last  = 1'b0;
      data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_i", int'(s_i), 0);
      chk("reset_q", int'(s_q), 0);
      chk("reset_ready", int'(ready), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // single byte 0x00 flagged last, regular strobes
      byte_q[0] = 8'h00;
      byte_q[1] = 8'h00;
      run_frame(1, 1, 1'b0, 100000);
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("first_i[%0d]", k), int'(cap_i[k]), hs[k]);
         chk($sformatf("first_q[%0d]", k), int'(cap_q[k]), (k < 5) ? 0 : hs[k-5]);
      end
      chk("sfd_lo_i", int'(cap_i[1280]), 1);
      chk("sfd_lo_q0", int'(cap_q[1280]), -7);
      chk("sfd_lo_q5", int'(cap_q[1285]), -1);
      chk("sfd_hi_i", int'(cap_i[1440]), -1);
      chk("sfd_hi_q", int'(cap_q[1440]), 7);
      for (int j = 0; j < 5; j++) begin
         chk($sformatf("c31_i[%0d]", j), int'(cap_i[1915+j]), hs[5+j]);
         chk($sformatf("c31_q[%0d]", j), int'(cap_q[1915+j]), -hs[j]);
         chk($sformatf("tail_i[%0d]", j), int'(cap_i[1920+j]), 0);
         chk($sformatf("tail_q[%0d]", j), int'(cap_q[1920+j]), -hs[5+j]);
      end
      chk("run1_done_at", done_at, 1925);
      chk("run1_done_cnt", done_cnt, 1);
      chk("run1_underrun_cnt", und_cnt, 0);
      chk("run1_stable", stable_err, 0);
      chk("run1_busy_after", int'(busy), 0);
      for (int k = 0; k < 2100; k++) begin
         ref_i[k] = cap_i[k];
         ref_q[k] = cap_q[k];
      end

      // byte 0x88: payload I unchanged, payload Q negated after the first half-pulse
      byte_q[0] = 8'h88;
      run_frame(1, 1, 1'b0, 100000);
      errs = 0;
      for (int k = 0; k < 1925; k++) begin
         if (cap_i[k] !== ref_i[k]) errs++;
         if (int'(cap_q[k]) != ((k >= 1605) ? -int'(ref_q[k]) : int'(ref_q[k]))) errs++;
      end
      chk("b88_sample_errs", errs, 0);
      chk("b88_q1605", int'(cap_q[1605]), -1);
      chk("b88_done_at", done_at, 1925);

      // two-byte frame with the second byte withheld
      byte_q[0] = 8'h00;
      byte_q[1] = 8'h55;
      run_frame(2, 1, 1'b0, 100000);
      chk("ur_underrun_at", und_at, 1920);
      chk("ur_underrun_cnt", und_cnt, 1);
      chk("ur_done_at", done_at, 1925);
      chk("ur_done_cnt", done_cnt, 1);
      chk("ur_busy_after", int'(busy), 0);
      errs = 0;
      for (int k = 0; k < 1925; k++)
         if (cap_i[k] !== ref_i[k] || cap_q[k] !== ref_q[k]) errs++;
      chk("ur_sample_errs", errs, 0);

      // reset in the middle of the payload
      byte_q[0] = 8'h00;
      run_frame(1, 1, 1'b0, 1650);
      chk("mid_done_cnt", done_cnt, 0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_i", int'(s_i), 0);
      chk("mid_rst_q", int'(s_q), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_ready", int'(ready), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // post-reset frame with irregular strobe gaps
      run_frame(1, 1, 1'b1, 100000);
      errs = 0;
      for (int k = 0; k < 1925; k++)
         if (cap_i[k] !== ref_i[k] || cap_q[k] !== ref_q[k]) errs++;
      chk("rnd_sample_errs", errs, 0);
      chk("rnd_stable", stable_err, 0);
      chk("rnd_done_at", done_at, 1925);
      chk("rnd_done_cnt", done_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
